// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
//
// Shared types and default timing for the VGA raster generator.
//
// Contents
//   vga_phase_t         per-axis raster phase (visible, front porch, sync,
//                       back porch), in the order a line or frame visits them
//   VGA_H_* / VGA_V_*   640x480@60 Hz timing in pixels / lines
//   VGA_H_TOTAL/V_TOTAL full line / frame lengths
// -----------------------------------------------------------------------------
package vga_pkg;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } vga_phase_t;

  // Horizontal timing in pixel clocks.
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  // Vertical timing in lines.
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

endpackage : vga_pkg

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
//
// One raster axis: a position counter 0..TOTAL-1 with a phase FSM that walks
// ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE. The phase changes on the same
// step that moves the position onto a region boundary, so the registered
// phase always describes the registered position.
//
// Parameters
//   ACTIVE, FP, SYNC, BP   region lengths in steps (each at least 1)
//
// Ports
//   clk         in   clock
//   reset       in   asynchronous, active-high reset (pos=0, phase=ACTIVE)
//   step        in   advance one position this clock
//   pos         out  current position
//   phase       out  current phase
//   phase_next  out  phase after this clock (equals phase when step=0)
//   wrap        out  step && pos==TOTAL-1 (position returns to 0 this clock)
// -----------------------------------------------------------------------------
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter  int ACTIVE = VGA_H_ACTIVE,
  parameter  int FP     = VGA_H_FP,
  parameter  int SYNC   = VGA_H_SYNC,
  parameter  int BP     = VGA_H_BP,
  localparam int TOTAL  = ACTIVE + FP + SYNC + BP,
  localparam int W      = $clog2(TOTAL)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           step,
  output logic [W-1:0]   pos,
  output vga_phase_t     phase,
  output vga_phase_t     phase_next,
  output logic           wrap
);

  // Last position of each region; reaching it with a step enters the next one.
  localparam logic [W-1:0] LAST_POS    = W'(TOTAL - 1);
  localparam logic [W-1:0] LAST_ACTIVE = W'(ACTIVE - 1);
  localparam logic [W-1:0] LAST_FRONT  = W'(ACTIVE + FP - 1);
  localparam logic [W-1:0] LAST_SYNC   = W'(ACTIVE + FP + SYNC - 1);

  logic [W-1:0] pos_next;

  // Next-state logic for both the counter and the phase FSM.
  always_comb begin
    // NOTE: every output of this block gets a value before any branch, so no
    // path can leave one unassigned and infer a latch.
    wrap       = step && (pos == LAST_POS);
    pos_next   = pos;
    phase_next = phase;

    if (step) begin
      pos_next = wrap ? '0 : pos + W'(1);

      unique case (phase)
        PH_ACTIVE: if (pos == LAST_ACTIVE) phase_next = PH_FRONT;
        PH_FRONT:  if (pos == LAST_FRONT)  phase_next = PH_SYNC;
        PH_SYNC:   if (pos == LAST_SYNC)   phase_next = PH_BACK;
        PH_BACK:   if (wrap)               phase_next = PH_ACTIVE;
        default:                           phase_next = PH_ACTIVE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos   <= '0;
      phase <= PH_ACTIVE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples its inputs from before the edge, independent of statement order.
      pos   <= pos_next;
      phase <= phase_next;
    end
  end

endmodule : vga_axis_counter

// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
//
// VGA raster timing generator. A horizontal axis counter steps once per pixel
// tick; the vertical axis counter steps on every horizontal wrap. Sync, video
// enable and line/frame pulses are registered from the next-state phases, so
// they always describe the x/y presented in the same cycle.
//
// Build option
//   VGA_TICK_DIV_EN  defined: pixel tick on every second enabled clock
//                    (e.g. 50 MHz clk -> 25 MHz pixels); the first tick comes
//                    on the second enabled clock after reset.
//                    undefined: pix_tick follows enable, one pixel per clock.
//
// Parameters
//   H_ACTIVE, H_FP, H_SYNC, H_BP   horizontal timing (pixels)
//   V_ACTIVE, V_FP, V_SYNC, V_BP   vertical timing (lines)
//
// Ports
//   clk          in   clock
//   reset        in   asynchronous, active-high reset
//   enable       in   1 = run, 0 = freeze counters and outputs
//   pix_tick     out  pixel-rate strobe; positions advance only when 1
//   x            out  horizontal position 0..H_TOTAL-1
//   y            out  vertical position 0..V_TOTAL-1
//   hsync        out  active-low horizontal sync
//   vsync        out  active-low vertical sync
//   video_on     out  1 while x < H_ACTIVE and y < V_ACTIVE
//   line_start   out  1-clock pulse in the cycle x wraps to 0
//   frame_start  out  1-clock pulse in the cycle x and y both wrap to 0
// -----------------------------------------------------------------------------
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter  int H_ACTIVE = VGA_H_ACTIVE,
  parameter  int H_FP     = VGA_H_FP,
  parameter  int H_SYNC   = VGA_H_SYNC,
  parameter  int H_BP     = VGA_H_BP,
  parameter  int V_ACTIVE = VGA_V_ACTIVE,
  parameter  int V_FP     = VGA_V_FP,
  parameter  int V_SYNC   = VGA_V_SYNC,
  parameter  int V_BP     = VGA_V_BP,
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW       = $clog2(H_TOTAL),
  localparam int VW       = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  output logic          pix_tick,
  output logic [HW-1:0] x,
  output logic [VW-1:0] y,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic          line_start,
  output logic          frame_start
);

  // ---------------------------------------------------------------------------
  // Pixel tick
  // ---------------------------------------------------------------------------
`ifdef VGA_TICK_DIV_EN
  logic div_q;

  // Toggles on each enabled clock; the tick is taken on the odd half so the
  // first pixel advance lands on the second enabled clock after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= 1'b0;
    end else if (enable) begin
      div_q <= ~div_q;
    end
  end

  assign pix_tick = enable & div_q;
`else
  assign pix_tick = enable;
`endif

  // ---------------------------------------------------------------------------
  // Axis counters
  // ---------------------------------------------------------------------------
  vga_phase_t h_phase, h_phase_next;
  vga_phase_t v_phase, v_phase_next;
  logic       h_wrap, v_wrap;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk        (clk),
    .reset      (reset),
    .step       (pix_tick),
    .pos        (x),
    .phase      (h_phase),
    .phase_next (h_phase_next),
    .wrap       (h_wrap)
  );

  // The vertical axis steps once per line, on the same edge x wraps to 0, so
  // its wrap already implies the horizontal wrap.
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk        (clk),
    .reset      (reset),
    .step       (h_wrap),
    .pos        (y),
    .phase      (v_phase),
    .phase_next (v_phase_next),
    .wrap       (v_wrap)
  );

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  // Decoding the next-state phases makes each registered output line up with
  // the x/y that the counters load on the same edge (zero latency).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      // Pulses are single-clock: they fall again on the following clock even
      // when the generator is frozen.
      line_start  <= h_wrap;
      frame_start <= v_wrap;

      if (pix_tick) begin
        hsync    <= (h_phase_next != PH_SYNC);
        vsync    <= (v_phase_next != PH_SYNC);
        video_on <= (h_phase_next == PH_ACTIVE) && (v_phase_next == PH_ACTIVE);
      end else begin
        // Positions are frozen; re-deriving from the held phases keeps the
        // outputs tied to the counters without a separate hold path.
        hsync    <= (h_phase != PH_SYNC);
        vsync    <= (v_phase != PH_SYNC);
        video_on <= (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
      end
    end
  end

endmodule : vga_sync_gen
